// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller: FSM encoding and N-bit
// saturation helpers evaluated on a wide signed carrier.
package pid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MP,
    ST_MI,
    ST_MD,
    ST_SUM
  } pid_state_e;

  // Wide enough to hold any intermediate of the datapath without overflow.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_max(input int n);
    logic signed [SAT_W-1:0] one;
    one = 64'sd1;
    return (one <<< (n - 1)) - one;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_min(input int n);
    return ~sat_max(n);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_n(input logic signed [SAT_W-1:0] x,
                                                    input int n);
    logic signed [SAT_W-1:0] r;
    r = x;
    if (x > sat_max(n)) begin
      r = sat_max(n);
    end else if (x < sat_min(n)) begin
      r = sat_min(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_core_fixed_mult_sat.sv
// Combinational fixed-point multiply: full product, arithmetic shift by FRAC
// (rounds toward -inf), then clip to the N-bit signed range.
module fixed_mult_sat #(
  parameter int N    = 19,
  parameter int FRAC = 10
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N:0]   b_i,
  output logic signed [N-1:0] y_o
);
  import pid_pkg::*;

  logic signed [2*N:0]     prod;
  logic signed [SAT_W-1:0] prod_shr;

  assign prod     = (2*N+1)'(a_i) * (2*N+1)'(b_i);
  assign prod_shr = SAT_W'(prod) >>> FRAC;
  assign y_o      = N'(sat_n(prod_shr, N));

endmodule

// File: rtl/pid_core.sv
// PID control effort u = P + I + D using one time-shared multiplier,
// conditional-integration anti-windup and a saturated registered output.
module pid_core #(
  parameter int N    = 19,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] ek,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  input  logic signed [N-1:0] kd,
  input  logic                clr_int,
  output logic                busy,
  output logic                out_valid,
  output logic signed [N-1:0] u,
  output logic                sat
);
  import pid_pkg::*;

  pid_state_e state_q, state_d;

  logic signed [N-1:0] acc_q, acc_d;
  logic signed [N-1:0] ek_prev_q, ek_prev_d;
  logic signed [N-1:0] u_q, u_d;
  logic                sat_q, sat_d;
  logic                out_valid_q, out_valid_d;

  logic signed [N-1:0] ek_q, kp_q, ki_q, kd_q;
  logic signed [N-1:0] p_q, q_q, icand_q, d_q;
  logic signed [N-1:0] icand_d;

  logic signed [N-1:0] mul_a;
  logic signed [N:0]   mul_b;
  logic signed [N-1:0] mul_y;
  logic signed [N:0]   ek_ext;
  logic signed [N:0]   ek_diff;

  logic signed [SAT_W-1:0] icand_w;
  logic signed [SAT_W-1:0] sum_w;
  logic signed [SAT_W-1:0] sum_sat;
  logic                    sum_clip;
  logic                    q_pos, q_neg;
  logic                    windup_hold;

  fixed_mult_sat #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mult (
    .a_i (mul_a),
    .b_i (mul_b),
    .y_o (mul_y)
  );

  assign ek_ext  = (N+1)'(ek_q);
  assign ek_diff = (N+1)'(ek_q) - (N+1)'(ek_prev_q);

  assign icand_w = SAT_W'(acc_q) + SAT_W'(mul_y);
  assign icand_d = N'(sat_n(icand_w, N));

  assign sum_w    = SAT_W'(p_q) + SAT_W'(icand_q) + SAT_W'(d_q);
  assign sum_sat  = sat_n(sum_w, N);
  assign sum_clip = (sum_w != sum_sat);

  // Freeze the integrator when it would push further into the clipped rail.
  assign q_pos       = !q_q[N-1] && (q_q != '0);
  assign q_neg       = q_q[N-1];
  assign windup_hold = sum_clip && (sum_w[SAT_W-1] ? q_neg : q_pos);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ek_prev_d   = ek_prev_q;
    u_d         = u_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    mul_a       = kp_q;
    mul_b       = ek_ext;
    case (state_q)
      ST_IDLE: begin
        if (clr_int) begin
          acc_d     = '0;
          ek_prev_d = '0;
        end
        if (start) begin
          state_d = ST_MP;
        end
      end
      ST_MP: begin
        state_d = ST_MI;
      end
      ST_MI: begin
        mul_a   = ki_q;
        state_d = ST_MD;
      end
      ST_MD: begin
        mul_a   = kd_q;
        mul_b   = ek_diff;
        state_d = ST_SUM;
      end
      ST_SUM: begin
        u_d         = sum_sat[N-1:0];
        sat_d       = sum_clip;
        out_valid_d = 1'b1;
        ek_prev_d   = ek_q;
        if (!windup_hold) begin
          acc_d = icand_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ek_prev_q   <= '0;
      u_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ek_prev_q   <= ek_prev_d;
      u_q         <= u_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand and partial-product registers carry no reset; they are always
  // written before being consumed within a computation.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      ek_q <= ek;
      kp_q <= kp;
      ki_q <= ki;
      kd_q <= kd;
    end
    case (state_q)
      ST_MP: p_q <= mul_y;
      ST_MI: begin
        q_q     <= mul_y;
        icand_q <= icand_d;
      end
      ST_MD: d_q <= mul_y;
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign u         = u_q;
  assign sat       = sat_q;

endmodule
